// File: rtl/button_debouncer.sv
// Button conditioner: 2-FF sync, tick-sampled debounce and registered change pulses per channel.
// Latency 2 clk + STABLE_TICKS ticks; no backpressure. `DEBOUNCE_REPEAT_EN adds hold auto-repeat.
module button_debouncer #(
    parameter int N            = 5,
    parameter int STABLE_TICKS = 20,
    parameter int CNT_W        = 5,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic [N-1:0] btn_raw,
    output logic [N-1:0] btn_db,
    output logic [N-1:0] btn_chg,
    output logic [N-1:0] btn_rep
);

    if (STABLE_TICKS < 1 || (STABLE_TICKS - 1) >= (2 ** CNT_W) ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_err
        $error("button_debouncer: illegal parameter combination");
    end

    logic [N-1:0]     sync1;
    logic [N-1:0]     s;
    logic [CNT_W-1:0] cnt [N];
    logic [N-1:0]     accept;
    logic [N-1:0]     db_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= btn_raw;
            s     <= sync1;
        end
    end

    // A channel accepts once its counter has seen STABLE_TICKS-1 differing ticks and a further one arrives.
    always_comb begin
        accept  = '0;
        db_next = btn_db;
        for (int i = 0; i < N; i++) begin
            if (tick && (s[i] != btn_db[i]) && (cnt[i] == CNT_W'(STABLE_TICKS - 1))) begin
                accept[i]  = 1'b1;
                db_next[i] = s[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_db  <= '0;
            btn_chg <= '0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            btn_db  <= db_next;
            btn_chg <= accept;
            for (int i = 0; i < N; i++) begin
                if (tick) begin
                    if (s[i] == btn_db[i] || accept[i])
                        cnt[i] <= '0;
                    else
                        cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int HOLD_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

    logic [HOLD_W-1:0] hold [N];

    // Cleared while low, on the rising cycle and on the falling cycle, so release never repeats.
    // After the first repeat the counter folds back to REPEAT_DELAY and stays bounded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_rep <= '0;
            for (int i = 0; i < N; i++) hold[i] <= '0;
        end else begin
            btn_rep <= '0;
            for (int i = 0; i < N; i++) begin
                if (!btn_db[i] || !db_next[i]) begin
                    hold[i] <= '0;
                end else if (tick) begin
                    if (hold[i] == HOLD_W'(REPEAT_DELAY + REPEAT_RATE - 1)) begin
                        btn_rep[i] <= 1'b1;
                        hold[i]    <= HOLD_W'(REPEAT_DELAY);
                    end else begin
                        hold[i] <= hold[i] + HOLD_W'(1);
                        if (hold[i] == HOLD_W'(REPEAT_DELAY - 1))
                            btn_rep[i] <= 1'b1;
                    end
                end
            end
        end
    end
`else
    assign btn_rep = '0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_TICKS=4, one tick every 4 clk.
module tb_button_debouncer;

    localparam int N = 5;
`ifdef DEBOUNCE_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         tick;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_db;
    logic [N-1:0] btn_chg;
    logic [N-1:0] btn_rep;

    int checks   = 0;
    int failures = 0;
    int chg_cnt [N] = '{default: 0};

    button_debouncer #(
        .N(N), .STABLE_TICKS(4), .CNT_W(5), .REPEAT_DELAY(8), .REPEAT_RATE(3)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .btn_raw(btn_raw),
        .btn_db(btn_db), .btn_chg(btn_chg), .btn_rep(btn_rep)
    );

    always #5 clk = ~clk;

    // Counts every change pulse per channel, sampled just after each edge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++)
            if (btn_chg[i] === 1'b1) chg_cnt[i] = chg_cnt[i] + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each tick unit: 3 idle clk, then one clk with tick high; returns at the negedge after it.
    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            repeat (3) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    int snap;
    logic [N-1:0] exp_rep;

    initial begin
        rst = 1'b1; tick = 1'b0; btn_raw = 5'b11111;

        // 1. reset with all buttons held
        repeat (3) @(negedge clk);
        check("rst_db", btn_db, 0);
        check("rst_chg", btn_chg, 0);
        check("rst_rep", btn_rep, 0);
        rst = 1'b0;
        ticks(3);
        check("rst_hold_db_3t", btn_db, 0);
        ticks(1);
        check("rst_hold_db_4t", btn_db, 5'b11111);
        check("rst_hold_chg", btn_chg, 5'b11111);
        @(negedge clk);
        check("rst_hold_chg_1clk", btn_chg, 0);
        btn_raw = 5'b00000;
        ticks(4);
        check("release_all_db", btn_db, 0);
        check("release_all_chg", btn_chg, 5'b11111);

        // 2. clean press on bit 0
        btn_raw = 5'b00001;
        ticks(3);
        check("press0_db_3t", btn_db, 0);
        ticks(1);
        check("press0_db_4t", btn_db, 5'b00001);
        check("press0_chg", btn_chg, 5'b00001);
        @(negedge clk);
        check("press0_chg_1clk", btn_chg, 0);

        // 3. bouncing bit 1
        snap = chg_cnt[1];
        for (int p = 0; p < 6; p++) begin
            btn_raw[1] = (p % 2 == 0);
            ticks(2);
            check("bounce_db", btn_db, 5'b00001);
        end
        btn_raw[1] = 1'b1;
        ticks(3);
        check("bounce_db_3t", btn_db, 5'b00001);
        ticks(1);
        check("bounce_db_4t", btn_db, 5'b00011);
        @(negedge clk);
        check("bounce_chg_count", chg_cnt[1] - snap, 1);

        // 4. release glitch on bit 2
        btn_raw[2] = 1'b1;
        ticks(4);
        check("glitch_setup_db", btn_db, 5'b00111);
        snap = chg_cnt[2];
        btn_raw[2] = 1'b0;
        ticks(3);
        btn_raw[2] = 1'b1;
        ticks(4);
        check("glitch_db", btn_db, 5'b00111);
        check("glitch_no_chg", chg_cnt[2] - snap, 0);
        btn_raw[2] = 1'b0;
        ticks(4);
        check("long_low_db", btn_db, 5'b00011);
        check("long_low_chg", btn_chg, 5'b00100);

        // 5. reset in the middle of a press on bit 4
        btn_raw[4] = 1'b1;
        ticks(2);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_db", btn_db, 0);
        check("midrst_chg", btn_chg, 0);
        rst = 1'b0;
        ticks(3);
        check("midrst_db_3t", btn_db, 0);
        ticks(1);
        check("midrst_db_4t", btn_db, 5'b10011);
        check("midrst_chg_4t", btn_chg, 5'b10011);

        // 6. hold bit 3 for auto-repeat, then release
        btn_raw = 5'b01000;
        ticks(4);
        check("rep_setup_db", btn_db, 5'b01000);
        check("rep_setup_chg", btn_chg, 5'b11011);
        check("rep_setup_rep", btn_rep, 0);
        for (int k = 1; k <= 24; k++) begin
            ticks(1);
            exp_rep = (REP_ON && (k == 8 || k == 11 || k == 14 || k == 17)) ? 5'b01000 : 5'b00000;
            check($sformatf("rep_tick%0d", k), btn_rep, exp_rep);
            if (k == 16) btn_raw = 5'b00000;
            if (k == 20) check("rep_release_db", btn_db, 0);
            @(negedge clk);
            check($sformatf("rep_after_tick%0d", k), btn_rep, 0);
            repeat (3) @(posedge clk);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
